// File: rtl/pc_fetch.sv
// Instruction fetch stage: drives the ROM address and queues fetched
// words in a two-entry FIFO for decode, with flush/branch redirect.
module pc_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        ce,
   output logic [31:0] pc,
   input  logic [31:0] inst_i,
   input  logic        flush,
   input  logic [31:0] new_pc,
   input  logic        branch_flag,
   input  logic [31:0] branch_target,
   output logic        if_valid,
   input  logic        id_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst
);

   logic        r_ce;
   logic [31:0] r_pc;
   logic [1:0]  r_cnt;
   logic        r_wp;
   logic        r_rp;
   logic [31:0] r_bpc  [BUF_DEPTH];
   logic [31:0] r_binst[BUF_DEPTH];

   logic        w_valid;
   logic        w_pop;
   logic        w_full;
   logic        w_issue;
   logic        w_redir;
   logic [31:0] w_target;
   logic [31:0] w_tgt_al;
   logic [1:0]  w_cnt_nxt;

   assign w_valid  = (r_cnt != 2'd0);
   assign w_pop    = w_valid & id_ready;
   assign w_full   = (r_cnt == 2'(BUF_DEPTH));
   assign w_issue  = r_ce & (~w_full | w_pop);
   assign w_redir  = flush | branch_flag;
   // flush wins over branch when both fire
   assign w_target = flush ? new_pc : branch_target;
   assign w_tgt_al = w_target & ~32'h3;

   always_comb begin
      w_cnt_nxt = r_cnt;
      unique case ({w_issue, w_pop})
         2'b10:   w_cnt_nxt = r_cnt + 2'd1;
         2'b01:   w_cnt_nxt = r_cnt - 2'd1;
         default: w_cnt_nxt = r_cnt;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ce  <= 1'b0;
         r_pc  <= RESET_PC;
         r_cnt <= 2'd0;
         r_wp  <= 1'b0;
         r_rp  <= 1'b0;
      end else begin
         r_ce <= 1'b1;
         if (w_redir) begin
            r_pc  <= w_tgt_al;
            r_cnt <= 2'd0;
            r_wp  <= 1'b0;
            r_rp  <= 1'b0;
         end else begin
            r_cnt <= w_cnt_nxt;
            if (w_issue) begin
               r_pc <= r_pc + 32'd4;
               r_wp <= ~r_wp;
            end
            if (w_pop) begin
               r_rp <= ~r_rp;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            r_bpc[i]   <= 32'd0;
            r_binst[i] <= 32'd0;
         end
      end else if (!w_redir && w_issue) begin
         r_bpc[r_wp]   <= r_pc;
         r_binst[r_wp] <= inst_i;
      end
   end

   assign ce       = r_ce;
   assign pc       = r_pc;
   assign if_valid = w_valid;
   assign if_pc    = w_valid ? r_bpc[r_rp]   : 32'd0;
   assign if_inst  = w_valid ? r_binst[r_rp] : 32'd0;

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_pc_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        ce;
   logic [31:0] pc;
   logic [31:0] inst_i;
   logic        flush;
   logic [31:0] new_pc;
   logic        branch_flag;
   logic [31:0] branch_target;
   logic        if_valid;
   logic        id_ready;
   logic [31:0] if_pc;
   logic [31:0] if_inst;

   int errors = 0;
   int checks = 0;

   pc_fetch dut (
      .clk          (clk),
      .rst          (rst),
      .ce           (ce),
      .pc           (pc),
      .inst_i       (inst_i),
      .flush        (flush),
      .new_pc       (new_pc),
      .branch_flag  (branch_flag),
      .branch_target(branch_target),
      .if_valid     (if_valid),
      .id_ready     (id_ready),
      .if_pc        (if_pc),
      .if_inst      (if_inst)
   );

   always #5 clk = ~clk;

   // ROM: word i holds value i
   function automatic logic [31:0] rom(input logic [31:0] a);
      return {2'b00, a[31:2]};
   endfunction

   assign inst_i = rom(pc);

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model
   logic        m_ce = 1'b0;
   logic [31:0] m_pc = 32'd0;
   logic [31:0] qpc[$];
   logic [31:0] qinst[$];
   logic        m_pop;
   logic        m_issue;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_ce = 1'b0;
         m_pc = 32'd0;
         qpc.delete();
         qinst.delete();
      end else begin
         m_pop   = (qpc.size() != 0) && id_ready;
         m_issue = m_ce && ((qpc.size() < 2) || m_pop);
         if (flush) begin
            qpc.delete();
            qinst.delete();
            m_pc = {new_pc[31:2], 2'b00};
         end else if (branch_flag) begin
            qpc.delete();
            qinst.delete();
            m_pc = {branch_target[31:2], 2'b00};
         end else begin
            if (m_pop) begin
               void'(qpc.pop_front());
               void'(qinst.pop_front());
            end
            if (m_issue) begin
               qpc.push_back(m_pc);
               qinst.push_back(rom(m_pc));
               m_pc = m_pc + 32'd4;
            end
         end
         m_ce = 1'b1;
      end
   end

   always @(negedge clk) begin
      chk("m_ce", ce, m_ce);
      chk("m_pc", pc, m_pc);
      chk("m_valid", if_valid, qpc.size() != 0);
      chk("m_if_pc", if_pc, (qpc.size() != 0) ? qpc[0] : 32'd0);
      chk("m_if_inst", if_inst, (qinst.size() != 0) ? qinst[0] : 32'd0);
   end

   task automatic head(input string name, input logic [31:0] p);
      chk({name, "_valid"}, if_valid, 1);
      chk({name, "_pc"}, if_pc, p);
      chk({name, "_inst"}, if_inst, rom(p));
   endtask

   initial begin
      rst           = 1'b0;
      id_ready      = 1'b0;
      flush         = 1'b0;
      branch_flag   = 1'b0;
      new_pc        = 32'd0;
      branch_target = 32'd0;
      #2;
      chk("rst_ce", ce, 0);
      chk("rst_pc", pc, 0);
      chk("rst_valid", if_valid, 0);
      chk("rst_if_pc", if_pc, 0);
      chk("rst_if_inst", if_inst, 0);
      #10 rst = 1'b1;

      @(negedge clk);
      chk("first_ce", ce, 1);
      chk("first_pc", pc, 0);
      chk("first_valid", if_valid, 0);
      id_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         head("stream", 32'(4 * k));
      end

      // stall with a fresh fill from address 0
      id_ready      = 1'b0;
      branch_flag   = 1'b1;
      branch_target = 32'd0;
      @(negedge clk);
      branch_flag = 1'b0;
      chk("stall_redir_pc", pc, 0);
      chk("stall_redir_valid", if_valid, 0);
      repeat (5) @(negedge clk);
      chk("stall_pc", pc, 32'd8);
      head("stall_h0", 32'd0);
      id_ready = 1'b1;
      @(negedge clk);
      head("stall_h1", 32'd4);
      @(negedge clk);
      head("stall_h2", 32'd8);

      // branch at full buffer
      id_ready = 1'b0;
      @(negedge clk);
      chk("full_valid", if_valid, 1);
      branch_flag   = 1'b1;
      branch_target = 32'h0000_0103;
      id_ready      = 1'b1;
      @(negedge clk);
      branch_flag = 1'b0;
      chk("br_valid", if_valid, 0);
      chk("br_pc", pc, 32'h100);
      @(negedge clk);
      head("br_head", 32'h100);

      // flush beats branch
      flush         = 1'b1;
      new_pc        = 32'h20;
      branch_flag   = 1'b1;
      branch_target = 32'h40;
      @(negedge clk);
      flush       = 1'b0;
      branch_flag = 1'b0;
      chk("prio_pc", pc, 32'h20);
      chk("prio_valid", if_valid, 0);
      @(negedge clk);
      head("prio_head", 32'h20);

      // back-to-back redirects
      branch_flag   = 1'b1;
      branch_target = 32'h200;
      @(negedge clk);
      chk("b2b_pc1", pc, 32'h200);
      branch_flag = 1'b0;
      flush       = 1'b1;
      new_pc      = 32'h301;
      @(negedge clk);
      flush = 1'b0;
      chk("b2b_pc2", pc, 32'h300);
      chk("b2b_valid", if_valid, 0);
      @(negedge clk);
      head("b2b_head", 32'h300);

      // pc wrap
      branch_flag   = 1'b1;
      branch_target = 32'hFFFF_FFF8;
      @(negedge clk);
      branch_flag = 1'b0;
      chk("wrap_pc", pc, 32'hFFFF_FFF8);
      @(negedge clk);
      head("wrap_h0", 32'hFFFF_FFF8);
      @(negedge clk);
      head("wrap_h1", 32'hFFFF_FFFC);
      @(negedge clk);
      head("wrap_h2", 32'h0000_0000);

      // asynchronous reset while full
      id_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_arst_valid", if_valid, 1);
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("arst_ce", ce, 0);
      chk("arst_valid", if_valid, 0);
      chk("arst_pc", pc, 0);
      chk("arst_if_pc", if_pc, 0);
      chk("arst_if_inst", if_inst, 0);
      @(negedge clk);
      #2 rst   = 1'b1;
      id_ready = 1'b1;
      @(negedge clk);
      chk("rel_ce", ce, 1);
      chk("rel_pc", pc, 0);
      chk("rel_valid", if_valid, 0);
      @(negedge clk);
      head("rel_h0", 32'd0);
      @(negedge clk);
      head("rel_h1", 32'd4);
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset; bits [1:0] SHALL be 00.
REQ-002 Parameter BUF_DEPTH, fixed at 2: number of instruction buffer entries; no other value is supported.
REQ-003 clk  input  1: single clock; all state SHALL change on its rising edge only.
REQ-004 rst  input  1: asynchronous, active-low reset.
REQ-005 ce  output  1: instruction ROM chip enable; registered.
REQ-006 pc  output  32: instruction ROM fetch address; registered; bits [1:0] always 00.
REQ-007 inst_i  input  32: ROM read data, combinationally valid in the same cycle as pc/ce.
REQ-008 flush  input  1: exception redirect request.
REQ-009 new_pc  input  32: exception target address.
REQ-010 branch_flag  input  1: branch redirect request.
REQ-011 branch_target  input  32: branch target address.
REQ-012 if_valid  output  1: buffer head holds a valid instruction for decode.
REQ-013 id_ready  input  1: decode accepts the head entry.
REQ-014 if_pc  output  32: PC of the head entry.
REQ-015 if_inst  output  32: instruction word of the head entry.

Function
REQ-016 Issue rule: when ce=1 and the buffer is not full, or a pop occurs in the same cycle, the block SHALL capture {pc, inst_i} into the buffer tail and SHALL advance pc to pc+4.
REQ-017 No issue: when the buffer is full and no pop occurs, pc SHALL hold, ce SHALL stay 1, and inst_i SHALL be ignored.
REQ-018 Pop rule: a pop SHALL occur on a cycle with if_valid=1 and id_ready=1; the head entry SHALL retire at that clock edge.
REQ-019 Occupancy: the buffer SHALL hold an occupancy counter with range 0..2; if_valid SHALL equal (count!=0).
REQ-020 Output mapping: if_pc and if_inst SHALL show the head entry; when count=0 they SHALL be 0.
REQ-021 Simultaneous pop and issue at count=2: count SHALL stay 2, the head SHALL advance, and the new entry SHALL be written.
REQ-022 Simultaneous pop and issue at count=1: count SHALL stay 1, and the issued entry SHALL become the head on the next cycle.
REQ-023 Ordering: the buffer SHALL be FIFO with no reordering; read and write pointers SHALL wrap modulo 2.
REQ-024 PC wrap: pc arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 SHALL give 32'h0000_0000.
REQ-025 Redirect: on a cycle with flush=1 or branch_flag=1, at that edge the block SHALL empty the buffer (count=0) and discard any same-cycle issue and pop.
REQ-026 Redirect target: on the same edge, pc SHALL load {target[31:2],2'b00}.
REQ-027 Redirect priority: flush SHALL take priority over branch_flag; with both asserted, new_pc is used.
REQ-028 Post-redirect: the first issue after a redirect SHALL occur in the next cycle at the target address; if_valid SHALL be 0 in the cycle after the redirect.
REQ-029 Back-to-back redirects: each redirect SHALL win on its own cycle; the last redirect determines pc.
REQ-030 Throughput: with id_ready held at 1 and no redirects, the block SHALL deliver one instruction per cycle after the first fill cycle.
REQ-031 Latency: an instruction fetched at pc in cycle N SHALL appear on if_inst in cycle N+1 at the earliest.

Reset
REQ-032 While rst=0, the following SHALL hold asynchronously: ce=0, pc=RESET_PC, count=0, pointers=0, if_valid=0, if_pc=0, if_inst=0.
REQ-033 On the first rising edge after rst deasserts, ce SHALL go to 1 with pc=RESET_PC, and no capture SHALL occur on that edge.
REQ-034 A reset asserted mid-operation SHALL discard all buffered entries immediately, without waiting for a clock edge.

Verification
REQ-035 Release reset, hold id_ready=1, use ROM contents mem[i]=i -> if_pc sequence 0,4,8,... and if_inst 0,1,2,... on consecutive cycles with if_valid=1.
REQ-036 Hold id_ready=0 for 5 cycles -> count reaches 2, pc freezes at 8, and entries pc=0 and pc=4 are retained; release id_ready -> 0,4,8 are delivered with no gap or duplication.
REQ-037 Assert branch_flag=1 with branch_target=32'h0000_0103 at count=2 -> next cycle if_valid=0 and pc=32'h100; the following cycle if_pc=32'h100.
REQ-038 Assert flush=1 with new_pc=32'h20 and branch_flag=1 with branch_target=32'h40 together -> pc=32'h20 and the buffer is empty.
REQ-039 Force pc near the top (branch_target=32'hFFFF_FFF8), id_ready=1 -> if_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-040 Pulse rst=0 between clock edges while count=2 -> ce, if_valid and pc go to their reset values immediately, without a clock edge.
